// File: rtl/vec_accel_pkg.sv
// Shared defaults for the vector-accelerator instruction path.
package vec_accel_pkg;

  localparam int unsigned INST_CHUNK_BITS = 8;
  localparam int unsigned INST_CHUNKS     = 2;
  localparam int unsigned INST_FIFO_DEPTH = 4;

endpackage : vec_accel_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; read data is the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Status flags, guarded handshakes and head read-out
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    count   = count_q;
    rdata   = mem_q[rd_q];
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Next-state for storage, pointers (wrap mod DEPTH) and occupancy
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule : sync_fifo

// File: rtl/inst_assembler.sv
// Assembles WORDS chunks of BITS (first chunk most significant) into one
// instruction and queues completed instructions in a DEPTH-entry FIFO.
module inst_assembler
  import vec_accel_pkg::*;
#(
  parameter int unsigned BITS  = INST_CHUNK_BITS,
  parameter int unsigned WORDS = INST_CHUNKS,
  parameter int unsigned DEPTH = INST_FIFO_DEPTH,
  localparam int unsigned IW = BITS * WORDS,
  localparam int unsigned PW = $clog2(WORDS),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [IW-1:0]   out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   count,
  output logic [PW-1:0]   partial
);

  localparam logic [PW-1:0] LAST_PTR = PW'(WORDS - 1);

  // The lowest slot is never registered: the last chunk goes straight
  // into the FIFO, so only WORDS-1 slots are held here.
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [IW-BITS-1:0] asm_q, asm_d;

  logic          accept, push, pop;
  logic          fifo_full, fifo_empty;
  logic [IW-1:0] push_data, fifo_rdata;
  logic [CW-1:0] fifo_count;

  // Handshakes and output gating; in_ready depends only on registered state and flush
  always_comb begin
    in_ready  = !flush && ((ptr_q != LAST_PTR) || !fifo_full);
    accept    = in_valid && in_ready;
    push      = accept && (ptr_q == LAST_PTR);
    push_data = {asm_q, in};
    out_valid = !fifo_empty;
    pop       = out_valid && out_ready;
    out       = out_valid ? fifo_rdata : '0;
    count     = fifo_count;
    partial   = ptr_q;
  end

  // Chunk pointer and assembly slots: chunk k lands in slot WORDS-1-k
  always_comb begin
    ptr_d = ptr_q;
    asm_d = asm_q;
    if (flush) begin
      ptr_d = '0;
      asm_d = '0;
    end else if (accept) begin
      if (ptr_q == LAST_PTR) begin
        ptr_d = '0;
        asm_d = '0;
      end else begin
        ptr_d = ptr_q + PW'(1);
        for (int unsigned s = 1; s < WORDS; s++) begin
          if (ptr_q == PW'(WORDS - 1 - s)) begin
            asm_d[(s - 1) * BITS +: BITS] = in;
          end
        end
      end
    end
  end

  // Assembly state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      asm_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      asm_q <= asm_d;
    end
  end

  sync_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule : inst_assembler

// File: tb/tb_inst_assembler.sv
// Directed, scoreboard-checked bench for inst_assembler (WORDS=2 and WORDS=4).
module tb_inst_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] out;
  logic [2:0]  count;
  logic [0:0]  partial;

  logic [7:0]  in4;
  logic        in4_valid, in4_ready, flush4, out4_valid, out4_ready;
  logic [31:0] out4;
  logic [2:0]  count4;
  logic [1:0]  partial4;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int pops4 = 0;
  logic [15:0] sb [$];
  logic [31:0] sb4 [$];

  always #5 clk = ~clk;

  inst_assembler #(.BITS(8), .WORDS(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .partial(partial)
  );

  inst_assembler #(.BITS(8), .WORDS(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .in_valid(in4_valid), .in_ready(in4_ready),
    .flush(flush4), .out(out4), .out_valid(out4_valid), .out_ready(out4_ready),
    .count(count4), .partial(partial4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the WORDS=2 instance: compare head on every handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=%h expected=none", out);
      end else begin
        chk("out_data", {16'h0, out}, {16'h0, sb.pop_front()});
        pops++;
      end
    end
  end

  // Scoreboard for the WORDS=4 instance
  always @(negedge clk) begin
    if (!rst && out4_valid && out4_ready) begin
      if (sb4.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb4_underflow observed=%h expected=none", out4);
      end else begin
        chk("out4_data", out4, sb4.pop_front());
        pops4++;
      end
    end
  end

  task automatic send(input logic [7:0] c);
    bit done = 1'b0;
    in = c;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept chunk=%h", c);
    end
  endtask

  task automatic send4(input logic [7:0] c);
    bit done = 1'b0;
    in4 = c;
    in4_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in4_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in4_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL send4_timeout observed=in_ready_low expected=accept chunk=%h", c);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (count == 0) break;
    end
    out_ready = 1'b0;
    chk("drain_count", {29'h0, count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in4 = '0; in4_valid = 1'b0; flush4 = 1'b0; out4_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out", {16'h0, out}, 32'd0);
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_partial", {31'h0, partial}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);

    // 1: basic two-beat assembly, one-cycle latency to out
    out_ready = 1'b1;
    send(8'h33);
    chk("t1_partial1", {31'h0, partial}, 32'd1);
    sb.push_back(16'h330F);
    send(8'h0F);
    chk("t1_out_valid", {31'h0, out_valid}, 32'd1);
    chk("t1_out", {16'h0, out}, 32'h330F);
    chk("t1_count1", {29'h0, count}, 32'd1);
    chk("t1_partial0", {31'h0, partial}, 32'd0);
    @(posedge clk); #1;
    chk("t1_count0", {29'h0, count}, 32'd0);
    chk("t1_out_valid0", {31'h0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // 2: fill FIFO, first chunk still accepted, last chunk stalls until a pop
    for (int k = 0; k < 4; k++) begin
      logic [7:0] hi, lo;
      hi = 8'(2 * k + 1);
      lo = 8'(2 * k + 2);
      sb.push_back({hi, lo});
      send(hi);
      send(lo);
    end
    chk("t2_full_count", {29'h0, count}, 32'd4);
    send(8'h5A);
    chk("t2_partial", {31'h0, partial}, 32'd1);
    in = 8'h6B;
    in_valid = 1'b1;
    #1;
    chk("t2_stall_ready", {31'h0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_stall_partial", {31'h0, partial}, 32'd1);
    chk("t2_stall_count", {29'h0, count}, 32'd4);
    sb.push_back(16'h5A6B);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t2_after_pop_count", {29'h0, count}, 32'd3);
    chk("t2_after_pop_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t2_refill_count", {29'h0, count}, 32'd4);
    chk("t2_refill_partial", {31'h0, partial}, 32'd0);
    drain();

    // 3: flush drops the partial chunk and blocks the chunk offered alongside it
    send(8'hAA);
    flush = 1'b1;
    in = 8'hBB;
    in_valid = 1'b1;
    #1;
    chk("t3_flush_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t3_flush_partial", {31'h0, partial}, 32'd0);
    chk("t3_flush_count", {29'h0, count}, 32'd0);
    sb.push_back(16'h1234);
    send(8'h12);
    send(8'h34);
    chk("t3_head", {16'h0, out}, 32'h1234);
    drain();

    // 4: simultaneous push and pop keeps count and order
    sb.push_back(16'hA1B1);
    send(8'hA1); send(8'hB1);
    sb.push_back(16'hA2B2);
    send(8'hA2); send(8'hB2);
    chk("t4_count2", {29'h0, count}, 32'd2);
    send(8'hC3);
    sb.push_back(16'hC3D4);
    in = 8'hD4;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t4_count_same", {29'h0, count}, 32'd2);
    chk("t4_partial", {31'h0, partial}, 32'd0);
    chk("t4_head_next", {16'h0, out}, 32'hA2B2);
    drain();

    // 5: reset mid-operation discards queued and partial instructions
    for (int k = 0; k < 6; k++) send(8'(8'h40 + k));
    send(8'h77);
    chk("t5_pre_count", {29'h0, count}, 32'd3);
    chk("t5_pre_partial", {31'h0, partial}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_out_valid", {31'h0, out_valid}, 32'd0);
    chk("t5_out", {16'h0, out}, 32'd0);
    chk("t5_count", {29'h0, count}, 32'd0);
    chk("t5_partial", {31'h0, partial}, 32'd0);
    chk("t5_in_ready", {31'h0, in_ready}, 32'd1);
    sb.push_back(16'h9ABC);
    send(8'h9A);
    send(8'hBC);
    drain();

    // 6: WORDS=4 with idle gaps between beats
    out4_ready = 1'b1;
    sb4.push_back(32'h11223344);
    send4(8'h11);
    chk("t6_partial1", {30'h0, partial4}, 32'd1);
    repeat (2) @(posedge clk); #1;
    send4(8'h22);
    chk("t6_partial2", {30'h0, partial4}, 32'd2);
    repeat (3) @(posedge clk); #1;
    send4(8'h33);
    chk("t6_partial3", {30'h0, partial4}, 32'd3);
    @(posedge clk); #1;
    send4(8'h44);
    chk("t6_partial0", {30'h0, partial4}, 32'd0);
    chk("t6_count1", {29'h0, count4}, 32'd1);
    chk("t6_out", out4, 32'h11223344);
    repeat (2) @(posedge clk); #1;
    chk("t6_count0", {29'h0, count4}, 32'd0);
    out4_ready = 1'b0;

    repeat (3) @(posedge clk); #1;
    chk("sb_left", sb.size(), 32'd0);
    chk("sb4_left", sb4.size(), 32'd0);
    chk("pops_total", pops, 32'd11);
    chk("pops4_total", pops4, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_assembler
